// File: rtl/code_lock_fsm.sv
// Keypad code lock: per-button release detectors feed an attempt/timeout/lockout FSM.
// Latency: release seen by detector next edge, state/flags one edge later. Optional relock: CODE_LOCK_RELOCK_EN.
module code_lock_fsm #(
    parameter  int NUM_BTN        = 4,
    parameter  int CODE_LEN       = 4,
    parameter  int MAX_ATTEMPTS   = 3,
    parameter  int TIMEOUT_CYCLES = 1_000_000_000,
    localparam int IDX_W          = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1,
    localparam int CNT_W          = $clog2(CODE_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_BTN-1:0]        btn,
    input  logic [CODE_LEN*IDX_W-1:0] code_seq,
    input  logic                      lock,
    output logic                      unlocked,
    output logic                      locked_out,
    output logic [3:0]                attempts_left,
    output logic [CNT_W-1:0]          entry_cnt,
    output logic [6:0]                ssg_d
);

    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CODE_LEN);
    localparam logic [3:0]       MAX_C    = 4'(MAX_ATTEMPTS);
    localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]       SSG_0    = 7'b1000000;
    localparam logic [6:0]       SSG_9    = 7'b0010000;
    localparam logic [6:0]       SSG_E    = 7'b0000110;

    typedef enum logic [1:0] {
        D_WAIT,
        D_HELD,
        D_REL
    } det_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_ERROR,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    det_t             r_det [NUM_BTN];
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_att;
    logic [31:0]      r_tmr;
    logic             r_unlocked;
    logic             r_locked_out;
    logic [6:0]       r_ssg;

    logic [NUM_BTN-1:0] w_rel;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_exp;
    logic               w_any;
    logic               w_valid;
    logic               w_hit;
    logic               w_tmo;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [31:0]        w_tmr_inc;

    // REL lasts exactly one cycle, so each release yields a single pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BTN; k++) r_det[k] <= D_WAIT;
        end else begin
            for (int k = 0; k < NUM_BTN; k++) begin
                case (r_det[k])
                    D_WAIT:  if (btn[k])  r_det[k] <= D_HELD;
                    D_HELD:  if (!btn[k]) r_det[k] <= D_REL;
                    default: r_det[k] <= D_WAIT;
                endcase
            end
        end
    end

    always_comb begin
        w_rel = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            w_rel[k] = (r_det[k] == D_REL);
            if (r_det[k] == D_REL) w_idx = IDX_W'(k);
        end
    end

    always_comb begin
        w_exp = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (r_cnt == CNT_W'(i)) w_exp = code_seq[i*IDX_W +: IDX_W];
        end
    end

    assign w_any     = |w_rel;
    assign w_valid   = $onehot(w_rel);
    assign w_hit     = w_valid && (w_idx == w_exp);
    assign w_tmo     = (r_tmr == TMO_LAST);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + 32'd1;

`ifndef CODE_LOCK_RELOCK_EN
    logic w_unused_lock;
    assign w_unused_lock = lock;
`endif

    // ERROR keeps absorbing entries until a full code length has been taken,
    // then spends one cycle charging the failed attempt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_att        <= MAX_C;
            r_tmr        <= '0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
            r_ssg        <= SSG_0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cnt <= w_cnt_inc;
                        r_tmr <= '0;
                        if (!w_hit) begin
                            r_state <= S_ERROR;
                        end else if (w_cnt_inc == LEN_C) begin
                            r_state    <= S_UNLOCKED;
                            r_unlocked <= 1'b1;
                            r_ssg      <= SSG_9;
                            r_att      <= MAX_C;
                        end else begin
                            r_state <= S_ENTRY;
                        end
                    end
                end
                S_ENTRY: begin
                    if (w_tmo) begin
                        r_state      <= S_LOCKOUT;
                        r_locked_out <= 1'b1;
                        r_ssg        <= SSG_E;
                    end else begin
                        r_tmr <= w_tmr_inc;
                        if (w_any) begin
                            r_cnt <= w_cnt_inc;
                            if (!w_hit) begin
                                r_state <= S_ERROR;
                            end else if (w_cnt_inc == LEN_C) begin
                                r_state    <= S_UNLOCKED;
                                r_unlocked <= 1'b1;
                                r_ssg      <= SSG_9;
                                r_att      <= MAX_C;
                                r_tmr      <= '0;
                            end
                        end
                    end
                end
                S_ERROR: begin
                    if (w_tmo) begin
                        r_state      <= S_LOCKOUT;
                        r_locked_out <= 1'b1;
                        r_ssg        <= SSG_E;
                    end else if (r_cnt == LEN_C) begin
                        r_cnt <= '0;
                        r_tmr <= '0;
                        r_att <= r_att - 4'd1;
                        if (r_att == 4'd1) begin
                            r_state      <= S_LOCKOUT;
                            r_locked_out <= 1'b1;
                            r_ssg        <= SSG_E;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tmr <= w_tmr_inc;
                        if (w_any) r_cnt <= w_cnt_inc;
                    end
                end
                S_UNLOCKED: begin
`ifdef CODE_LOCK_RELOCK_EN
                    if (lock) begin
                        r_state    <= S_IDLE;
                        r_unlocked <= 1'b0;
                        r_ssg      <= SSG_0;
                        r_cnt      <= '0;
                        r_att      <= MAX_C;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign unlocked      = r_unlocked;
    assign locked_out    = r_locked_out;
    assign attempts_left = r_att;
    assign entry_cnt     = r_cnt;
    assign ssg_d         = r_ssg;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Randomised bench for code_lock_fsm against an attempt-level reference model.
module tb_code_lock_fsm;

    localparam int NB = 4;
    localparam int CL = 4;
    localparam int MA = 3;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [7:0] code_seq;
    logic       lock;
    logic       unlocked;
    logic       locked_out;
    logic [3:0] attempts_left;
    logic [2:0] entry_cnt;
    logic [6:0] ssg_d;

    code_lock_fsm #(
        .NUM_BTN(NB), .CODE_LEN(CL), .MAX_ATTEMPTS(MA), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .code_seq(code_seq), .lock(lock),
        .unlocked(unlocked), .locked_out(locked_out), .attempts_left(attempts_left),
        .entry_cnt(entry_cnt), .ssg_d(ssg_d)
    );

    always #5 clk = ~clk;

    wire [15:0] dut_vec = {unlocked, locked_out, attempts_left, entry_cnt, ssg_d};
    localparam logic [15:0] RST_VEC = {1'b0, 1'b0, 4'd3, 3'd0, 7'b1000000};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: attempt = list of entries; decided once CL entries are in.
    int m_code[CL];
    int m_q[$];
    int m_att;
    bit m_unl;
    bit m_lo;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input int a, input int b, input int c, input int d);
        m_code[0] = a; m_code[1] = b; m_code[2] = c; m_code[3] = d;
        code_seq = {2'(d), 2'(c), 2'(b), 2'(a)};
    endtask

    task automatic model_reset;
        m_q.delete();
        m_att = MA;
        m_unl = 1'b0;
        m_lo  = 1'b0;
    endtask

    task automatic model_entry(input int v);
        bit ok;
        if (m_unl || m_lo) return;
        m_q.push_back(v);
        if (m_q.size() == CL) begin
            ok = 1'b1;
            for (int i = 0; i < CL; i++) if (m_q[i] != m_code[i]) ok = 1'b0;
            if (ok) begin
                m_unl = 1'b1;
                m_att = MA;
            end else begin
                m_att--;
                m_q.delete();
                if (m_att == 0) m_lo = 1'b1;
            end
        end
    endtask

    function automatic logic [15:0] model_vec();
        int         c = m_unl ? CL : m_q.size();
        logic [6:0] s = m_lo ? 7'b0000110 : (m_unl ? 7'b0010000 : 7'b1000000);
        return {m_unl, m_lo, 4'(m_att), 3'(c), s};
    endfunction

    function automatic int idx_of(input logic [3:0] m);
        int n = 0;
        int p = -1;
        for (int k = 0; k < 4; k++) if (m[k]) begin n++; p = k; end
        return (n == 1) ? p : -1;
    endfunction

    task automatic release_entry(input logic [3:0] mask, input int hold);
        btn = mask;
        repeat (hold) tick;
        btn = '0;
        model_entry(idx_of(mask));
    endtask

    task automatic entry(input logic [3:0] mask);
        release_entry(mask, 2);
        repeat (4) tick;
    endtask

    task automatic apply_reset;
        btn   = '0;
        lock  = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        tick;
        model_reset();
    endtask

    task automatic test_reset;
        apply_reset();
        n_cmp++;
        if (dut_vec !== RST_VEC) begin
            n_err++; $display("FAIL reset_vec: got %h want %h", dut_vec, RST_VEC);
        end
        n_cmp++;
        if (ssg_d !== 7'b1000000) begin
            n_err++; $display("FAIL reset_ssg: got %b want %b", ssg_d, 7'b1000000);
        end
    endtask

    task automatic test_unlock;
        apply_reset();
        set_code(2, 1, 1, 0);
        entry(4'b0100);
        entry(4'b0010);
        entry(4'b0010);
        release_entry(4'b0001, 2);
        tick;
        n_cmp++;
        if (unlocked !== 1'b0) begin
            n_err++; $display("FAIL unlock_early: got %b want 0", unlocked);
        end
        tick;
        n_cmp++;
        if (unlocked !== 1'b1) begin
            n_err++; $display("FAIL unlock_latency: got %b want 1", unlocked);
        end
        n_cmp++;
        if ({ssg_d, attempts_left} !== {7'b0010000, 4'd3}) begin
            n_err++; $display("FAIL unlock_ssg_att: got %b/%0d want 0010000/3", ssg_d, attempts_left);
        end
    endtask

    task automatic test_wrong_code;
        apply_reset();
        set_code(2, 1, 1, 0);
        entry(4'b0100);
        entry(4'b1000);
        n_cmp++;
        if (entry_cnt !== 3'd2) begin
            n_err++; $display("FAIL wrong_cnt2: got %0d want 2", entry_cnt);
        end
        entry(4'b0001 << $urandom_range(0, 3));
        release_entry(4'b0001 << $urandom_range(0, 3), 2);
        tick;
        tick;
        n_cmp++;
        if ({entry_cnt, attempts_left} !== {3'd4, 4'd3}) begin
            n_err++; $display("FAIL wrong_cnt4: got cnt %0d att %0d want 4/3", entry_cnt, attempts_left);
        end
        tick;
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_err++; $display("FAIL wrong_idle: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_lockout;
        apply_reset();
        set_code(2, 1, 1, 0);
        for (int a = 0; a < MA; a++) begin
            for (int e = 0; e < CL; e++) entry(4'b1000);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL lockout_att%0d: got %h want %h", a, dut_vec, model_vec());
            end
        end
        entry(4'b0100); entry(4'b0010); entry(4'b0010); entry(4'b0001);
        n_cmp++;
        if ({unlocked, locked_out, ssg_d} !== {1'b0, 1'b1, 7'b0000110}) begin
            n_err++; $display("FAIL lockout_terminal: got %b%b %b want 01 0000110", unlocked, locked_out, ssg_d);
        end
    endtask

    task automatic test_simultaneous;
        apply_reset();
        set_code(2, 1, 1, 0);
        entry(4'b0110);
        n_cmp++;
        if (entry_cnt !== 3'd1) begin
            n_err++; $display("FAIL simul_cnt: got %0d want 1", entry_cnt);
        end
        entry(4'b0010); entry(4'b0010); entry(4'b0001);
        n_cmp++;
        if (dut_vec !== model_vec() || attempts_left !== 4'd2) begin
            n_err++; $display("FAIL simul_fail: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_timeout;
        int n;
        apply_reset();
        set_code(2, 1, 1, 0);
        release_entry(4'b0100, 2);
        n = 0;
        while (locked_out !== 1'b1 && n < 2 * TO) begin
            tick;
            n++;
        end
        n_cmp++;
        if (n != TO + 2) begin
            n_err++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO + 2);
        end
        n_cmp++;
        if ({locked_out, ssg_d} !== {1'b1, 7'b0000110}) begin
            n_err++; $display("FAIL timeout_flag: got %b %b want 1 0000110", locked_out, ssg_d);
        end
        apply_reset();
        entry(4'b0100);
        entry(4'b0010);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec !== RST_VEC) begin
            n_err++; $display("FAIL midreset_async: got %h want %h", dut_vec, RST_VEC);
        end
        tick;
        reset = 1'b0;
        tick;
        n_cmp++;
        if (dut_vec !== RST_VEC) begin
            n_err++; $display("FAIL midreset_after: got %h want %h", dut_vec, RST_VEC);
        end
    endtask

    task automatic test_relock;
        logic [15:0] want;
        apply_reset();
        set_code(2, 1, 1, 0);
        entry(4'b0100); entry(4'b0010); entry(4'b0010); entry(4'b0001);
        n_cmp++;
        if (unlocked !== 1'b1) begin
            n_err++; $display("FAIL relock_pre: got %b want 1", unlocked);
        end
        lock = 1'b1;
        tick;
        lock = 1'b0;
        tick;
`ifdef CODE_LOCK_RELOCK_EN
        want = RST_VEC;
`else
        want = {1'b1, 1'b0, 4'd3, 3'd4, 7'b0010000};
`endif
        n_cmp++;
        if (dut_vec !== want) begin
            n_err++; $display("FAIL relock_post: got %h want %h", dut_vec, want);
        end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        set_code(2, 1, 1, 0);
        for (int a = 0; a < 2; a++) begin
            for (int e = 0; e < CL; e++) begin
                logic [3:0] m;
                m = (a == 0) ? 4'b1000 : (4'b0001 << m_code[e]);
                release_entry(m, 2);
                tick;
            end
            repeat (4) tick;
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_err++; $display("FAIL b2b_attempt%0d: got %h want %h", a, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            apply_reset();
            set_code($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            for (int e = 0; e < 16; e++) begin
                int         u;
                int         a;
                logic [3:0] m;
                if (m_unl || m_lo) break;
                u = $urandom_range(0, 9);
                if (u < 1) begin
                    a = $urandom_range(0, 3);
                    m = (4'b0001 << a) | (4'b0001 << ((a + 1 + $urandom_range(0, 2)) % 4));
                end else if (u < 7) begin
                    m = 4'b0001 << m_code[m_q.size()];
                end else begin
                    m = 4'b0001 << $urandom_range(0, 3);
                end
                release_entry(m, $urandom_range(1, 3));
                repeat (4) tick;
                n_cmp++;
                if (dut_vec !== model_vec()) begin
                    n_err++; $display("FAIL random r%0d e%0d mask %b: got %h want %h", r, e, m, dut_vec, model_vec());
                end
            end
        end
    endtask

    initial begin
        btn      = '0;
        lock     = 1'b0;
        reset    = 1'b1;
        code_seq = 8'h16;
        test_reset();
        test_unlock();
        test_wrong_code();
        test_lockout();
        test_simultaneous();
        test_timeout();
        test_relock();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
